// File: rtl/mem_port_sched.sv
// mem_port_sched: round-robin scheduler for one fixed-latency data-memory port, one access in flight.
// Optional build macro MEM_SCHED_STORE_PRIO_EN: any valid store wins arbitration over all loads.
module mem_port_sched #(
  parameter int NREQ      = 2,
  parameter int WIDTH_MEM = 4,
  parameter int WIDTH_REG = 5,
  parameter int LAT       = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NREQ-1:0]           i_req_val,
  input  logic [NREQ-1:0]           i_req_we,
  input  logic [NREQ*WIDTH_MEM-1:0] i_req_addr,
  input  logic [NREQ*32-1:0]        i_req_wdata,
  input  logic [NREQ*2-1:0]         i_req_size,
  input  logic [NREQ*WIDTH_REG-1:0] i_req_tag,
  output logic [NREQ-1:0]           o_req_rdy,
  output logic                      o_mem_en,
  output logic                      o_mem_we,
  output logic [WIDTH_MEM-1:0]      o_mem_addr,
  output logic [31:0]               o_mem_wdata,
  output logic [1:0]                o_mem_size,
  input  logic [31:0]               i_mem_rdata,
  output logic                      o_rsp_val,
  output logic [WIDTH_REG-1:0]      o_rsp_tag,
  output logic [31:0]               o_rsp_data,
  output logic [$clog2(NREQ)-1:0]   o_rsp_src,
  input  logic                      i_rsp_rdy,
  input  logic                      i_kill
);
  localparam int SW = $clog2(NREQ);
  localparam int CW = $clog2(LAT+1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic                 we;
    logic [WIDTH_MEM-1:0] addr;
    logic [31:0]          wdata;
    logic [1:0]           size;
    logic [WIDTH_REG-1:0] tag;
    logic [SW-1:0]        src;
  } cmd_t;

  logic [NREQ-1:0][WIDTH_MEM-1:0] req_addr;
  logic [NREQ-1:0][31:0]          req_wdata;
  logic [NREQ-1:0][1:0]           req_size;
  logic [NREQ-1:0][WIDTH_REG-1:0] req_tag;

  assign req_addr  = i_req_addr;
  assign req_wdata = i_req_wdata;
  assign req_size  = i_req_size;
  assign req_tag   = i_req_tag;

  state_t               state, nxt;
  cmd_t                 cmd;
  logic [SW-1:0]        rr, rr_nxt, gnt_idx;
  logic [NREQ-1:0]      gnt;
  logic [CW-1:0]        cnt;
  logic                 killed, accept, last_wait;
  logic [31:0]          ld_data, rsp_data;
  logic [WIDTH_REG-1:0] rsp_tag;
  logic [SW-1:0]        rsp_src;

  // first set bit of m at or after p, wrapping; descending scan lets the nearest one win
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] m, input logic [SW-1:0] p);
    logic [NREQ-1:0] g;
    int idx;
    g = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      idx = (int'(p) + i) % NREQ;
      if (m[idx]) begin
        g      = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
`ifdef MEM_SCHED_STORE_PRIO_EN
    if (|(i_req_val & i_req_we)) gnt = rr_pick(i_req_val & i_req_we, rr);
    else                         gnt = rr_pick(i_req_val, rr);
`else
    gnt = rr_pick(i_req_val, rr);
`endif
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) gnt_idx = SW'(i);
  end

  assign rr_nxt    = (gnt_idx == SW'(NREQ-1)) ? '0 : gnt_idx + SW'(1);
  assign accept    = (state == S_IDLE) && |(i_req_val & gnt) && !i_rst;
  assign last_wait = (cnt == CW'(1));

  always_comb begin
    case (cmd.size)
      2'd0:    ld_data = {24'b0, i_mem_rdata[7:0]};
      2'd1:    ld_data = {16'b0, i_mem_rdata[15:0]};
      default: ld_data = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    o_req_rdy = '0;
    case (state)
      S_IDLE: begin
        o_req_rdy = i_rst ? '0 : gnt;
        if (accept) nxt = S_CMD;
      end
      S_CMD:  nxt = S_WAIT;
      S_WAIT: if (last_wait) nxt = (cmd.we || killed || i_kill) ? S_IDLE : S_RESP;
      S_RESP: if (i_kill || i_rsp_rdy) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr       <= '0;
      cmd      <= '0;
      cnt      <= '0;
      killed   <= 1'b0;
      rsp_data <= '0;
      rsp_tag  <= '0;
      rsp_src  <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          rr     <= rr_nxt;
          cmd    <= '{we: i_req_we[gnt_idx], addr: req_addr[gnt_idx], wdata: req_wdata[gnt_idx],
                      size: req_size[gnt_idx], tag: req_tag[gnt_idx], src: gnt_idx};
          killed <= 1'b0;
        end
        S_CMD: begin
          cnt <= CW'(LAT);
          if (i_kill && !cmd.we) killed <= 1'b1;
        end
        S_WAIT: begin
          cnt <= cnt - CW'(1);
          // a kill only matters for loads; the memory access itself always completes
          if (i_kill && !cmd.we) killed <= 1'b1;
          if (last_wait) begin
            rsp_data <= ld_data;
            rsp_tag  <= cmd.tag;
            rsp_src  <= cmd.src;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_en    = (state == S_CMD);
  assign o_mem_we    = o_mem_en & cmd.we;
  assign o_mem_addr  = cmd.addr;
  assign o_mem_wdata = cmd.wdata;
  assign o_mem_size  = cmd.size;
  assign o_rsp_val   = (state == S_RESP);
  assign o_rsp_tag   = rsp_tag;
  assign o_rsp_data  = rsp_data;
  assign o_rsp_src   = rsp_src;

endmodule

// File: tb/tb_mem_port_sched.sv
// Scoreboard bench for mem_port_sched: byte RAM with LAT read latency, reference memory, expected-response queue.
module tb_mem_port_sched;
  localparam int NREQ = 2, WM = 4, WR = 5, LAT = 2;

  typedef struct packed {
    logic          src;
    logic [WR-1:0] tag;
    logic [31:0]   data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, rsp_rdy, kill, preload;
  logic [NREQ-1:0]          val, we;
  logic [NREQ-1:0][WM-1:0]  addr;
  logic [NREQ-1:0][31:0]    wdata;
  logic [NREQ-1:0][1:0]     size;
  logic [NREQ-1:0][WR-1:0]  tag;
  logic [NREQ-1:0]          req_rdy;
  logic                     mem_en, mem_we, rsp_val;
  logic [WM-1:0]            mem_addr;
  logic [31:0]              mem_wdata, mem_rdata, rsp_data;
  logic [1:0]               mem_size;
  logic [WR-1:0]            rsp_tag;
  logic [$clog2(NREQ)-1:0]  rsp_src;

  mem_port_sched #(.NREQ(NREQ), .WIDTH_MEM(WM), .WIDTH_REG(WR), .LAT(LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_val(val), .i_req_we(we), .i_req_addr(addr),
    .i_req_wdata(wdata), .i_req_size(size), .i_req_tag(tag), .o_req_rdy(req_rdy),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_size(mem_size), .i_mem_rdata(mem_rdata), .o_rsp_val(rsp_val), .o_rsp_tag(rsp_tag),
    .o_rsp_data(rsp_data), .o_rsp_src(rsp_src), .i_rsp_rdy(rsp_rdy), .i_kill(kill)
  );

  int n_tot = 0, n_bad = 0;

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", t, got, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      4: return 8'h11;
      5: return 8'h22;
      6: return 8'h33;
      7: return 8'h44;
      default: return 8'(8'hC0 + i);
    endcase
  endfunction

  // environment RAM: byte-addressed, little-endian, read data valid LAT cycles after the strobe
  logic [7:0]  ram [16];
  logic [31:0] rd_pipe [1:LAT];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_byte(i);
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata[7:0];
      if (mem_size != 2'd0) ram[mem_addr + 4'd1] <= mem_wdata[15:8];
      if (mem_size[1]) begin
        ram[mem_addr + 4'd2] <= mem_wdata[23:16];
        ram[mem_addr + 4'd3] <= mem_wdata[31:24];
      end
    end
    rd_pipe[1] <= (mem_en && !mem_we) ?
      {ram[mem_addr + 4'd3], ram[mem_addr + 4'd2], ram[mem_addr + 4'd1], ram[mem_addr]} : 32'hA5A5_5A5A;
    for (int k = 2; k <= LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[LAT];

  // reference memory and scoreboard
  logic [7:0] ref_mem [16];
  exp_t       sbq [$];

  function automatic logic [31:0] ref_word(input logic [WM-1:0] a, input logic [1:0] sz);
    logic [31:0] w;
    w = {ref_mem[a + 4'd3], ref_mem[a + 4'd2], ref_mem[a + 4'd1], ref_mem[a]};
    case (sz)
      2'd0:    return {24'b0, w[7:0]};
      2'd1:    return {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input logic [WM-1:0] a, input logic [31:0] d, input logic [1:0] sz);
    ref_mem[a] = d[7:0];
    if (sz != 2'd0) ref_mem[a + 4'd1] = d[15:8];
    if (sz[1]) begin
      ref_mem[a + 4'd2] = d[23:16];
      ref_mem[a + 4'd3] = d[31:24];
    end
  endtask

  int cyc = 0, en_cyc = 0, rsp_cyc = 0, acc_cyc = 0, rsp_count = 0;
  logic rsp_prev = 1'b0, multi_hot = 1'b0;
  logic [31:0] last_data = '0;
  logic [NREQ-1:0] gseq [8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_en) en_cyc <= cyc;
    if (rsp_val && !rsp_prev) rsp_cyc <= cyc;
    rsp_prev <= rsp_val;
    if ($countones(req_rdy) > 1) multi_hot <= 1'b1;
    if (rsp_val && rsp_rdy && !kill) begin
      rsp_count <= rsp_count + 1;
      last_data <= rsp_data;
      if (sbq.size() == 0) chk("rsp_unexpected", 64'(rsp_tag), 64'hFFFF);
      else begin
        chk("rsp_tag",  64'(rsp_tag),  64'(sbq[0].tag));
        chk("rsp_data", 64'(rsp_data), 64'(sbq[0].data));
        chk("rsp_src",  64'(rsp_src),  64'(sbq[0].src));
        sbq.delete(0);
      end
    end
  end

  task automatic reset_dut();
    rst = 1'b1; preload = 1'b1; val = '0; we = '0; kill = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_byte(i);
    sbq.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; preload = 1'b0;
  endtask

  function automatic exp_t mk_exp(input int k);
    return '{src: 1'(k), tag: tag[k], data: ref_word(addr[k], size[k])};
  endfunction

  // serve n grants from whatever requests the caller has raised
  task automatic serve(input int n, input bit once, input bit push);
    bit got;
    int idx;
    for (int g = 0; g < n; g++) begin
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
        @(negedge clk);
        if (|req_rdy) got = 1'b1;
      end
      chk("grant_timeout", 64'(got), 64'd1);
      if (!got) break;
      gseq[g] = req_rdy;
      acc_cyc = cyc;
      idx = req_rdy[1] ? 1 : 0;
      if (we[idx]) ref_store(addr[idx], wdata[idx], size[idx]);
      else if (push) sbq.push_back(mk_exp(idx));
      @(posedge clk); #1;
      if (once) val[idx] = 1'b0;
    end
    val = '0;
  endtask

  task automatic do_req(input int k, input bit w, input logic [WM-1:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic [WR-1:0] t, input bit push);
    @(posedge clk); #1;
    we[k] = w; addr[k] = a; wdata[k] = d; size[k] = sz; tag[k] = t; val[k] = 1'b1;
    serve(1, 1'b1, push);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sbq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp();
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_val) got = 1'b1;
    end
    chk("rsp_timeout", 64'(got), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  int saved;
  logic [31:0] held;

  initial begin
    addr = '0; wdata = '0; size = '0; tag = '0; rsp_rdy = 1'b1;
    reset_dut();
    @(negedge clk);
    chk("rst_rdy",     64'(req_rdy),  64'd0);
    chk("rst_mem_en",  64'(mem_en),   64'd0);
    chk("rst_rsp_val", 64'(rsp_val),  64'd0);
    chk("rst_addr",    64'(mem_addr), 64'd0);
    chk("rst_tag",     64'(rsp_tag),  64'd0);

    // 1: word load, latency and data
    do_req(0, 1'b0, 4'd4, 32'h0, 2'd2, 5'd7, 1'b1);
    wait_drain();
    chk("t1_cmd_lat", 64'(en_cyc - acc_cyc), 64'd1);
    chk("t1_rsp_lat", 64'(rsp_cyc - en_cyc), 64'(LAT + 1));
    chk("t1_data",    64'(last_data),        64'h44332211);

    // 2: both requesters always valid, grants alternate
    reset_dut();
    we = '0; addr[0] = 4'd4; size[0] = 2'd2; tag[0] = 5'd1;
    addr[1] = 4'd0; size[1] = 2'd1; tag[1] = 5'd2;
    val = 2'b11;
    serve(4, 1'b0, 1'b1);
    chk("t2_g0", 64'(gseq[0]), 64'b01);
    chk("t2_g1", 64'(gseq[1]), 64'b10);
    chk("t2_g2", 64'(gseq[2]), 64'b01);
    chk("t2_g3", 64'(gseq[3]), 64'b10);
    wait_drain();

    // 3: store then narrow and wide loads of the same location
    saved = rsp_count;
    do_req(0, 1'b1, 4'd8, 32'hDEADBEEF, 2'd2, 5'd0, 1'b0);
    repeat (6) @(posedge clk);
    chk("t3_store_norsp", 64'(rsp_count), 64'(saved));
    chk("t3_ram", 64'({ram[11], ram[10], ram[9], ram[8]}), 64'hDEADBEEF);
    do_req(1, 1'b0, 4'd8, 32'h0, 2'd0, 5'd3, 1'b1);
    wait_drain();
    chk("t3_byte", 64'(last_data), 64'h000000EF);
    do_req(0, 1'b0, 4'd8, 32'h0, 2'd1, 5'd4, 1'b1);
    wait_drain();
    chk("t3_half", 64'(last_data), 64'h0000BEEF);
    do_req(1, 1'b0, 4'd8, 32'h0, 2'd3, 5'd5, 1'b1);
    wait_drain();
    chk("t3_size3", 64'(last_data), 64'hDEADBEEF);
    do_req(0, 1'b1, 4'd14, 32'h0BADF00D, 2'd1, 5'd0, 1'b0);
    do_req(0, 1'b0, 4'd15, 32'h0, 2'd2, 5'd6, 1'b1);
    wait_drain();

    // 4: kill in WAIT; IDLE again exactly when an unkilled load would be in RESP
    saved = rsp_count;
    do_req(0, 1'b0, 4'd4, 32'h0, 2'd2, 5'd8, 1'b0);
    @(posedge clk); #1 kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    addr[0] = 4'd4; size[0] = 2'd0; tag[0] = 5'd9; we[0] = 1'b0; val[0] = 1'b1;
    @(negedge clk);
    chk("t4_busy", 64'(req_rdy), 64'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_idle", 64'(req_rdy), 64'b01);
    chk("t4_norsp_val", 64'(rsp_val), 64'd0);
    @(posedge clk); #1;
    sbq.push_back(mk_exp(0));
    val = '0;
    chk("t4_norsp", 64'(rsp_count), 64'(saved));
    wait_drain();

    // kill during CMD, then kill in IDLE alongside an accept
    saved = rsp_count;
    do_req(1, 1'b0, 4'd0, 32'h0, 2'd2, 5'd10, 1'b0);
    kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    repeat (6) @(posedge clk);
    chk("t4_cmdkill_norsp", 64'(rsp_count), 64'(saved));
    #1;
    addr[0] = 4'd5; size[0] = 2'd1; tag[0] = 5'd11; we[0] = 1'b0; val[0] = 1'b1; kill = 1'b1;
    @(negedge clk);
    chk("t4_idle_kill_gnt", 64'(req_rdy), 64'b01);
    sbq.push_back(mk_exp(0));
    @(posedge clk); #1 val = '0; kill = 1'b0;
    wait_drain();
    chk("t4_idle_kill_data", 64'(last_data), 64'h00003322);

    // 5: back-pressured response stays stable and blocks new grants
    rsp_rdy = 1'b0;
    do_req(0, 1'b0, 4'd4, 32'h0, 2'd2, 5'd12, 1'b1);
    addr[1] = 4'd0; size[1] = 2'd2; tag[1] = 5'd13; we[1] = 1'b0; val[1] = 1'b1;
    wait_rsp();
    held = rsp_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_val",  64'(rsp_val),  64'd1);
      chk("t5_tag",  64'(rsp_tag),  64'd12);
      chk("t5_data", 64'(rsp_data), 64'(held));
      chk("t5_rdy",  64'(req_rdy),  64'b00);
    end
    @(posedge clk); #1 rsp_rdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_drop", 64'(rsp_val), 64'd0);
    chk("t5_idle", 64'(req_rdy), 64'b10);
    sbq.push_back(mk_exp(1));
    @(posedge clk); #1 val = '0;
    wait_drain();
    chk("t5_data_val", 64'(held), 64'h44332211);

    // kill in RESP beats i_rsp_rdy
    rsp_rdy = 1'b0;
    saved = rsp_count;
    do_req(0, 1'b0, 4'd4, 32'h0, 2'd0, 5'd14, 1'b0);
    wait_rsp();
    @(posedge clk); #1 kill = 1'b1; rsp_rdy = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    @(negedge clk);
    chk("t5_kill_drop", 64'(rsp_val), 64'd0);
    chk("t5_kill_norsp", 64'(rsp_count), 64'(saved));

    // reset in WAIT: no response afterwards
    do_req(1, 1'b0, 4'd4, 32'h0, 2'd2, 5'd15, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    chk("rst_mid_norsp", 64'(rsp_count), 64'(saved));

    // 6: load on req0 vs store on req1 from rr = 0
    reset_dut();
    addr[0] = 4'd12; size[0] = 2'd2; tag[0] = 5'd16; we[0] = 1'b0;
    addr[1] = 4'd12; size[1] = 2'd2; wdata[1] = 32'h12345678; we[1] = 1'b1;
    val = 2'b11;
    serve(2, 1'b1, 1'b1);
`ifdef MEM_SCHED_STORE_PRIO_EN
    chk("t6_first",  64'(gseq[0]), 64'b10);
    chk("t6_second", 64'(gseq[1]), 64'b01);
`else
    chk("t6_first",  64'(gseq[0]), 64'b01);
    chk("t6_second", 64'(gseq[1]), 64'b10);
`endif
    wait_drain();

    chk("one_hot_rdy", 64'(multi_hot), 64'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
